// File: rtl/ttt_pkg.sv
// Shared types and line-geometry helpers for the tic-tac-toe judge.
// line_mask enumerates rows, then columns, then both diagonals.
package ttt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    COMMIT
  } judge_state_t;

  localparam int MAX_DIM   = 16;
  localparam int MAX_CELLS = MAX_DIM * MAX_DIM;

  function automatic int lines_of(input int rows,
                                  input int cols);
    return rows + cols + 2;
  endfunction

  // Wide result; callers truncate to their own CELLS.
  function automatic logic [MAX_CELLS-1:0] line_mask(
    input int idx,
    input int rows,
    input int cols
  );
    logic [MAX_CELLS-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_DIM; i++) begin
      if (idx < rows) begin
        if (i < cols) m[idx*cols + i] = 1'b1;
      end else if (idx < rows + cols) begin
        if (i < rows) m[i*cols + (idx - rows)] = 1'b1;
      end else if (idx == rows + cols) begin
        if (i < rows) m[i*cols + i] = 1'b1;
      end else begin
        if (i < rows) m[i*cols + (cols - 1 - i)] = 1'b1;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/judge_line_mask.sv
// Combinational line index to cell mask lookup.
// Thin wrapper so the mask table can be checked on its own.
module judge_line_mask
  import ttt_pkg::*;
#(
  parameter int ROWS = 3,
  parameter int COLS = 3,
  localparam int CELLS = ROWS * COLS,
  localparam int LINES = lines_of(ROWS, COLS),
  localparam int IW    = $clog2(LINES)
) (
  input  logic [IW-1:0]    idx_i,
  output logic [CELLS-1:0] mask_o
);

  // Pick out the cells belonging to the indexed line.
  always_comb begin
    mask_o = CELLS'(line_mask(int'(idx_i), ROWS, COLS));
  end

endmodule

// File: rtl/game_judge.sv
// Tic-tac-toe judge: scans one line per cycle over a latched board
// and commits win/full/error flags in a single final cycle.
module game_judge
  import ttt_pkg::*;
#(
  parameter int ROWS = 3,
  parameter int COLS = 3,
  localparam int CELLS = ROWS * COLS
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             make_judge_req,
  output logic             make_judge_ready,
  input  logic [CELLS-1:0] board_a,
  input  logic [CELLS-1:0] board_b,
  output logic             end_of_game,
  output logic             win_a,
  output logic             win_b,
  output logic             board_error
);

  localparam int LINES = lines_of(ROWS, COLS);
  localparam int IW    = $clog2(LINES);

  if (ROWS != COLS) begin : g_dim_chk
    $error("game_judge: ROWS must equal COLS");
  end

  judge_state_t     state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             acc_a_q, acc_a_d;
  logic             acc_b_q, acc_b_d;
  logic [CELLS-1:0] la_q, la_d;
  logic [CELLS-1:0] lb_q, lb_d;
  logic             win_a_q, win_a_d;
  logic             win_b_q, win_b_d;
  logic             err_q, err_d;
  logic             eog_q, eog_d;
  logic [CELLS-1:0] mask;
  logic             full;

  judge_line_mask #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_mask (
    .idx_i  (idx_q),
    .mask_o (mask)
  );

  assign full = &(la_q | lb_q);

  assign make_judge_ready =
    (state_q == IDLE) & ~make_judge_req & reset_n;

  assign win_a       = win_a_q;
  assign win_b       = win_b_q;
  assign board_error = err_q;
  assign end_of_game = eog_q;

  // Next-state and result logic for the scan FSM.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_a_d = acc_a_q;
    acc_b_d = acc_b_q;
    la_d    = la_q;
    lb_d    = lb_q;
    win_a_d = win_a_q;
    win_b_d = win_b_q;
    err_d   = err_q;
    eog_d   = eog_q;
    case (state_q)
      IDLE: begin
        if (make_judge_req) begin
          la_d    = board_a;
          lb_d    = board_b;
          idx_d   = '0;
          acc_a_d = 1'b0;
          acc_b_d = 1'b0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        acc_a_d = acc_a_q | ((la_q & mask) == mask);
        acc_b_d = acc_b_q | ((lb_q & mask) == mask);
        if (idx_q == IW'(LINES - 1)) begin
          state_d = COMMIT;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      COMMIT: begin
        win_a_d = acc_a_q;
        win_b_d = acc_b_q;
        err_d   = |(la_q & lb_q);
        eog_d   = acc_a_q | acc_b_q | full | (|(la_q & lb_q));
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        acc_a_d = 1'b0;
        acc_b_d = 1'b0;
      end
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      acc_a_q <= 1'b0;
      acc_b_q <= 1'b0;
      la_q    <= '0;
      lb_q    <= '0;
      win_a_q <= 1'b0;
      win_b_q <= 1'b0;
      err_q   <= 1'b0;
      eog_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_a_q <= acc_a_d;
      acc_b_q <= acc_b_d;
      la_q    <= la_d;
      lb_q    <= lb_d;
      win_a_q <= win_a_d;
      win_b_q <= win_b_d;
      err_q   <= err_d;
      eog_q   <= eog_d;
    end
  end

endmodule

// File: tb/tb_game_judge.sv
// Directed and random checks of game_judge against a
// rule-level tic-tac-toe reference model.
module tb_game_judge;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       req = 1'b0;
  logic       ready;
  logic [8:0] board_a = '0;
  logic [8:0] board_b = '0;
  logic       eog, wa, wb, err;

  int nchecks = 0;
  int nerr = 0;

  logic pa, pb, perr, peog;

  always #5 clk = ~clk;

  game_judge dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .make_judge_req   (req),
    .make_judge_ready (ready),
    .board_a          (board_a),
    .board_b          (board_b),
    .end_of_game      (eog),
    .win_a            (wa),
    .win_b            (wb),
    .board_error      (err)
  );

  function automatic logic owns(input logic [8:0] p);
    logic w;
    w = 1'b0;
    for (int r = 0; r < 3; r++)
      w |= p[3*r] & p[3*r+1] & p[3*r+2];
    for (int c = 0; c < 3; c++)
      w |= p[c] & p[c+3] & p[c+6];
    w |= p[0] & p[4] & p[8];
    w |= p[2] & p[4] & p[6];
    return w;
  endfunction

  task automatic chk(input string tag, input int got,
                     input int exp);
    nchecks++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic ea,
                          input logic eb, input logic ee,
                          input logic eg);
    chk({tag, ".win_a"}, int'(wa), int'(ea));
    chk({tag, ".win_b"}, int'(wb), int'(eb));
    chk({tag, ".err"}, int'(err), int'(ee));
    chk({tag, ".eog"}, int'(eog), int'(eg));
  endtask

  task automatic model(input logic [8:0] a, input logic [8:0] b);
    pa   = owns(a);
    pb   = owns(b);
    perr = (a & b) != 9'h0;
    peog = pa | pb | perr | ((a | b) == 9'h1FF);
  endtask

  // Req in cycle T, wait for ready, expect it at T+10.
  task automatic judge(input logic [8:0] a, input logic [8:0] b,
                       input string tag, input bit hold_chk);
    int n;
    @(negedge clk);
    board_a = a;
    board_b = b;
    req = 1'b1;
    #1;
    chk({tag, ".rdy_T"}, int'(ready), 0);
    @(negedge clk);
    req = 1'b0;
    board_a = 9'($urandom);
    board_b = 9'($urandom);
    #1;
    n = 1;
    while (!ready && n < 20) begin
      if (hold_chk && n == 5) chk_outs({tag, ".hold"}, pa, pb, perr, peog);
      @(negedge clk);
      #1;
      n++;
    end
    chk({tag, ".lat"}, n, 10);
    model(a, b);
    chk_outs(tag, pa, pb, perr, peog);
  endtask

  initial begin
    int n;
    pa = 0; pb = 0; perr = 0; peog = 0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst.rdy", int'(ready), 0);
    chk_outs("rst", 0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rel.rdy", int'(ready), 1);

    judge(9'h000, 9'h000, "empty", 1);
    judge(9'h049, 9'h006, "col0", 1);
    judge(9'h054, 9'h003, "anti", 1);
    judge(9'h18D, 9'h072, "draw", 1);
    judge(9'h001, 9'h002, "none", 1);
    judge(9'h001, 9'h001, "ovl", 1);
    judge(9'h000, 9'h111, "diagb", 1);
    judge(9'h1FF, 9'h1FF, "both", 1);
    judge(9'h0A8, 9'h038, "bothw", 1);

    // Busy request at T+3 and board change at T+4 are ignored.
    @(negedge clk);
    board_a = 9'h038;
    board_b = 9'h000;
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    board_a = 9'h007;
    board_b = 9'h007;
    n = 4;
    #1;
    while (!ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("busy.lat", n, 10);
    model(9'h038, 9'h000);
    chk_outs("busy", pa, pb, perr, peog);
    repeat (12) begin
      @(negedge clk);
      #1;
      chk("busy.idle", int'(ready), 1);
    end
    chk_outs("busy.stable", pa, pb, perr, peog);

    // Reset in the middle of a scan.
    @(negedge clk);
    board_a = 9'h000;
    board_b = 9'h000;
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mid.rdy", int'(ready), 0);
    chk_outs("mid", 0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("mid.rdy2", int'(ready), 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("mid.rel", int'(ready), 1);
    pa = 0; pb = 0; perr = 0; peog = 0;
    judge(9'h1C0, 9'h000, "post", 1);

    for (int i = 0; i < 40; i++) begin
      logic [8:0] a, b;
      a = 9'($urandom);
      b = 9'($urandom);
      if ($urandom_range(0, 3) != 0) b = b & ~a;
      judge(a, b, $sformatf("rnd%0d", i), 1);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
